// File: rtl/ex_mul_alu.sv
// ex_mul_alu: execute-stage ALU with an iterative shift-add multiplier.
//   Single-cycle ops (and/xor/add/sll/addi/sub/srai/or/reserved) register
//   their result one edge after acceptance. mul walks one multiplier bit
//   per cycle for WIDTH cycles, holding stall_o high while busy.
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   valid_i             operation presented this cycle
//   ALUCtrl_i[3:0]      operation code
//   data1_i, data2_i    operands A and B
//   stall_o             busy (state==MUL), upstream must hold
//   valid_o             one-cycle pulse: data_o carries a new result
//   data_o              registered result
//   zero_o              data_o == 0 (combinational)
module ex_mul_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             stall_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRAI = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt, alu_res;
  logic [CW-1:0]    cnt;
  logic [4:0]       shamt;
  logic             accept, is_mul, last;

  assign shamt  = data2_i[4:0];
  assign accept = (state == IDLE) && valid_i;
  assign is_mul = (ALUCtrl_i == OP_MUL);
  assign last   = (state == MUL) && (cnt == CW'(WIDTH - 1));
  // Partial product: add the shifted multiplicand when the current LSB is set.
  assign acc_nxt = acc + (mplier[0] ? mcand : '0);

  // Single-cycle result; mul and reserved codes yield 0 here.
  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      OP_AND:  alu_res = data1_i & data2_i;
      OP_XOR:  alu_res = data1_i ^ data2_i;
      OP_ADD,
      OP_ADDI: alu_res = data1_i + data2_i;
      OP_SUB:  alu_res = data1_i - data2_i;
      OP_SLL:  alu_res = data1_i << shamt;
      OP_SRAI: alu_res = $unsigned($signed(data1_i) >>> shamt);
      OP_OR:   alu_res = data1_i | data2_i;
      default: alu_res = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && is_mul) state_nxt = MUL;
      MUL:  if (last)             state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall_o = (state == MUL);
    zero_o  = (data_o == '0);
  end

  // Datapath. Inputs are only sampled in IDLE, so anything driven during
  // MUL cannot disturb the latched operands.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand  <= data1_i;
          mplier <= data2_i;
          acc    <= '0;
          cnt    <= '0;
        end else begin
          data_o  <= alu_res;
          valid_o <= 1'b1;
        end
      end else if (state == MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (last) begin
          data_o  <= acc_nxt;
          valid_o <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ex_mul_alu.sv
module tb_ex_mul_alu;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_MUL  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SRAI = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_RSV  = 4'b1111;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [3:0]  ALUCtrl_i = '0;
  logic [31:0] data1_i = '0, data2_i = '0;
  logic        stall_o, valid_o, zero_o;
  logic [31:0] data_o;

  ex_mul_alu #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ALUCtrl_i(ALUCtrl_i),
    .data1_i(data1_i), .data2_i(data2_i), .stall_o(stall_o),
    .valid_o(valid_o), .data_o(data_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          at;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid_o pulse must match the oldest expected result,
  // including the cycle it was due in.
  always @(negedge clk_i) begin
    if (valid_o) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_data", data_o, e.d);
        chk("res_zero", {31'd0, zero_o}, {31'd0, e.d == 32'd0});
        chk("res_cycle", cyc, e.at);
      end
    end
  end

  // Called just after a negedge; returns just after the negedge where the
  // next op may be presented (the valid_o cycle for mul, so no bubble).
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv);
    exp_t e;
    valid_i = 1'b1; ALUCtrl_i = op; data1_i = a; data2_i = b;
    e.d  = expv;
    e.at = cyc + ((op == OP_MUL) ? 33 : 1);
    sb.push_back(e);
    if (op != OP_MUL) begin
      @(negedge clk_i);
      valid_i = 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        @(negedge clk_i);
        chk("stall_busy", {31'd0, stall_o}, 32'd1);
        valid_i = 1'b1; ALUCtrl_i = 4'($urandom);
        data1_i = $urandom; data2_i = $urandom;
      end
      @(negedge clk_i);
      chk("stall_done", {31'd0, stall_o}, 32'd0);
      valid_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst_data", data_o, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd1);
    rst_i = 1'b0;
    @(negedge clk_i);

    issue(OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008);
    issue(OP_SUB,  32'h0000_0007, 32'h0000_0007, 32'h0000_0000);
    issue(OP_SRAI, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    issue(OP_SRAI, 32'h7000_0000, 32'h0000_0004, 32'h0700_0000);
    issue(OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000);
    issue(OP_SLL,  32'h0000_1234, 32'h0000_0020, 32'h0000_1234);
    issue(OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    issue(OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    issue(OP_XOR,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    issue(OP_ADDI, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    issue(OP_SUB,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
    issue(OP_RSV,  32'h1234_5678, 32'h1234_5678, 32'h0000_0000);
    @(negedge clk_i);

    issue(OP_MUL,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE);
    @(negedge clk_i);
    // 12345 * 6789 = 83810205, then add presented in the valid_o cycle
    issue(OP_MUL,  32'd12345, 32'd6789, 32'h04FE_D79D);
    issue(OP_ADD,  32'd1, 32'd1, 32'h0000_0002);
    @(negedge clk_i);

    // Reset in the middle of a mul: no result may follow.
    valid_i = 1'b1; ALUCtrl_i = OP_MUL; data1_i = 32'd3; data2_i = 32'd5;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (9) @(negedge clk_i);
    chk("mid_mul_stall", {31'd0, stall_o}, 32'd1);
    #1 rst_i = 1'b1;
    #1;
    chk("async_rst_data", data_o, 32'd0);
    chk("async_rst_stall", {31'd0, stall_o}, 32'd0);
    chk("async_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("async_rst_zero", {31'd0, zero_o}, 32'd1);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (40) @(negedge clk_i);
    issue(OP_ADD, 32'd2, 32'd2, 32'h0000_0004);
    repeat (3) @(negedge clk_i);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
